fix_readout_ctrl: RTL and testbench

//  Sequences host readout of a completed FIX message from the message buffer RAM.

---
 rtl/fix_readout_ctrl.sv | 150 +++++++++++++++
 tb/tb_fix_readout_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_readout_ctrl.sv
// Host readout sequencer for a completed FIX message: walks the buffer from index 0 to
// final_index, prefetching each byte and holding it on data_out_2 until the host consumes it.
module fix_readout_ctrl #(
  parameter int              ADDR_W  = 8,
  parameter int              DATA_W  = 8,
  parameter int              MEM_LAT = 1,
  parameter logic [7:0]      CMD_ACK = 8'hdd
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fix_message_sent,
  input  logic [ADDR_W-1:0] final_index,
  input  logic [7:0]        session_initiate,
  input  logic              host_rd,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out_2,
  output logic              msg_valid,
  output logic              msg_last,
  output logic              msg_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [1:0]        LAT_INIT = 2'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_flag_q, last_flag_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its peers, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      last_q      <= '0;
      lat_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      last_q      <= last_d;
      lat_cnt_q   <= lat_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_flag_q <= last_flag_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: every next-state variable is defaulted to its current value first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    last_d      = last_q;
    lat_cnt_d   = lat_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_flag_d = last_flag_q;
    done_d      = done_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (fix_message_sent) begin
          last_d  = final_index;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        lat_cnt_d = LAT_INIT;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          data_d      = mem_rdata;
          valid_d     = 1'b1;
          last_flag_d = (index_q == last_q);
          state_d     = S_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      S_HOLD: begin
        if (host_rd) begin
          valid_d     = 1'b0;
          last_flag_d = 1'b0;
          // Compare before incrementing so a full-range message never wraps the index.
          if (index_q == last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            index_d = index_q + IDX_ONE;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (fix_message_sent && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    // The release/abort command overrides anything decided above in the same cycle.
    if (session_initiate == CMD_ACK) begin
      valid_d     = 1'b0;
      last_flag_d = 1'b0;
      done_d      = 1'b0;
      overrun_d   = 1'b0;
      data_d      = '0;
      index_d     = '0;
      state_d     = S_IDLE;
    end
  end

  assign mem_rd     = (state_q == S_FETCH);
  assign mem_addr   = index_q;
  assign data_out_2 = data_q;
  assign msg_valid  = valid_q;
  assign msg_last   = last_flag_q;
  assign msg_done   = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fix_readout_ctrl.sv
// Self-checking bench: two instances (MEM_LAT=1 and MEM_LAT=3) with buffer models that
// return X unless the read strobe and latency line up; a queue holds the expected bytes.
module tb_fix_readout_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] final_index;
  logic [7:0] session_initiate;

  logic       fms1, hrd1, rd1, valid1, last1, done1, ovr1;
  logic [7:0] addr1, rdata1, dout1;
  logic       fms3, hrd3, rd3, valid3, last3, done3, ovr3;
  logic [7:0] addr3, rdata3, dout3;

  logic [7:0] mem [256];
  logic [7:0] p1, s1, s2, s3;
  int         rd_cnt1 = 0;
  int         rd_cnt3 = 0;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fix_readout_ctrl #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .CMD_ACK(8'hdd)) dut (
    .clk(clk), .reset(reset), .fix_message_sent(fms1), .final_index(final_index),
    .session_initiate(session_initiate), .host_rd(hrd1), .mem_rd(rd1), .mem_addr(addr1),
    .mem_rdata(rdata1), .data_out_2(dout1), .msg_valid(valid1), .msg_last(last1),
    .msg_done(done1), .overrun(ovr1)
  );

  fix_readout_ctrl #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .CMD_ACK(8'hdd)) dut3 (
    .clk(clk), .reset(reset), .fix_message_sent(fms3), .final_index(final_index),
    .session_initiate(session_initiate), .host_rd(hrd3), .mem_rd(rd3), .mem_addr(addr3),
    .mem_rdata(rdata3), .data_out_2(dout3), .msg_valid(valid3), .msg_last(last3),
    .msg_done(done3), .overrun(ovr3)
  );

  // Buffer models: data appears exactly MEM_LAT cycles after the strobe, X otherwise.
  always @(posedge clk) begin
    p1 <= rd1 ? mem[addr1] : 8'hxx;
    s1 <= rd3 ? mem[addr3] : 8'hxx;
    s2 <= s1;
    s3 <= s2;
    if (rd1) rd_cnt1 <= rd_cnt1 + 1;
    if (rd3) rd_cnt3 <= rd_cnt3 + 1;
  end
  assign rdata1 = p1;
  assign rdata3 = s3;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int fi);
    for (int i = 0; i <= fi; i++) sb.push_back('{data: mem[i], last: (i == fi)});
  endtask

  task automatic pulse_fms(input bit sel, input logic [7:0] fi);
    final_index = fi;
    if (sel) fms3 = 1'b1; else fms1 = 1'b1;
    tick();
    fms1 = 1'b0;
    fms3 = 1'b0;
  endtask

  task automatic send_ack();
    session_initiate = 8'hdd;
    tick();
    session_initiate = 8'h00;
  endtask

  // Consume n bytes: wait (bounded) for msg_valid, compare against the queue, pulse host_rd.
  task automatic drain(input bit sel, input int n);
    exp_t e;
    int   cyc;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!(sel ? valid3 : valid1) && cyc < 40) begin
        tick();
        cyc++;
      end
      if (!(sel ? valid3 : valid1)) begin
        check("valid_timeout", sel ? valid3 : valid1, 1);
        return;
      end
      if (sb.size() == 0) begin
        check("unexpected_byte", sel ? valid3 : valid1, 0);
        return;
      end
      e = sb.pop_front();
      check("rd_data", sel ? dout3 : dout1, e.data);
      check("rd_last", sel ? last3 : last1, e.last);
      if (sel) hrd3 = 1'b1; else hrd1 = 1'b1;
      tick();
      hrd1 = 1'b0;
      hrd3 = 1'b0;
      check("valid_clear", sel ? valid3 : valid1, 0);
    end
  endtask

  initial begin
    int snap;
    reset = 1'b1;
    final_index = '0;
    session_initiate = '0;
    fms1 = 0; hrd1 = 0; fms3 = 0; hrd3 = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5a;
    tick();
    tick();
    check("rst_valid", valid1, 0);
    check("rst_done", done1, 0);
    check("rst_overrun", ovr1, 0);
    check("rst_mem_rd", rd1, 0);
    check("rst_addr", addr1, 0);
    check("rst_data", dout1, 0);
    check("rst_last", last1, 0);
    #2 reset = 1'b0;

    // 1: four-byte message
    mem[0] = 8'h38; mem[1] = 8'h3d; mem[2] = 8'h46; mem[3] = 8'h49;
    pulse_fms(0, 8'd3);
    push_msg(3);
    drain(0, 4);
    check("t1_done", done1, 1);

    // 3a: host_rd in DONE changes nothing
    hrd1 = 1'b1;
    tick();
    hrd1 = 1'b0;
    check("t3_done_hold", done1, 1);
    check("t3_done_addr", addr1, 3);
    check("t3_done_data", dout1, 8'h49);
    send_ack();
    check("t1_ack_done", done1, 0);
    check("t1_ack_data", dout1, 0);

    // 2: one-byte message, exact latency
    snap = rd_cnt1;
    pulse_fms(0, 8'd0);
    check("t2_mem_rd_e1", rd1, 1);
    check("t2_addr_e1", addr1, 0);
    check("t2_valid_e1", valid1, 0);
    tick();
    check("t2_mem_rd_e2", rd1, 0);
    check("t2_valid_e2", valid1, 0);
    tick();
    check("t2_valid_e3", valid1, 1);
    check("t2_last", last1, 1);
    check("t2_data", dout1, 8'h38);
    hrd1 = 1'b1;
    tick();
    hrd1 = 1'b0;
    check("t2_done", done1, 1);
    tick();
    check("t2_done_held", done1, 1);
    check("t2_rd_count", rd_cnt1 - snap, 1);
    send_ack();
    check("t2_ack_done", done1, 0);

    // 3b: host_rd in IDLE, FETCH and WAIT is ignored
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    hrd1 = 1'b1;
    tick();
    check("t3_idle_addr", addr1, 0);
    check("t3_idle_data", dout1, 0);
    check("t3_idle_valid", valid1, 0);
    hrd1 = 1'b0;
    pulse_fms(0, 8'd2);
    push_msg(2);
    hrd1 = 1'b1;
    tick();
    check("t3_wait_addr", addr1, 0);
    tick();
    hrd1 = 1'b0;
    check("t3_first_valid", valid1, 1);
    drain(0, 3);
    check("t3_done", done1, 1);
    send_ack();

    // 4: second message mid-readout sets overrun, original length kept
    mem[0] = 8'h38; mem[1] = 8'h3d; mem[2] = 8'h46; mem[3] = 8'h49;
    pulse_fms(0, 8'd3);
    push_msg(3);
    drain(0, 1);
    pulse_fms(0, 8'd1);
    check("t4_overrun", ovr1, 1);
    drain(0, 3);
    check("t4_done", done1, 1);
    check("t4_overrun_sticky", ovr1, 1);
    send_ack();
    check("t4_ack_overrun", ovr1, 0);

    // 5: abort together with host_rd in HOLD at index 2
    pulse_fms(0, 8'd3);
    push_msg(3);
    drain(0, 2);
    while (!valid1) tick();
    check("t5_addr_before", addr1, 2);
    session_initiate = 8'hdd;
    hrd1 = 1'b1;
    tick();
    session_initiate = 8'h00;
    hrd1 = 1'b0;
    check("t5_valid", valid1, 0);
    check("t5_data", dout1, 0);
    check("t5_done", done1, 0);
    check("t5_addr", addr1, 0);
    sb.delete();
    tick();
    check("t5_idle_mem_rd", rd1, 0);
    pulse_fms(0, 8'd1);
    push_msg(1);
    check("t5_restart_addr", addr1, 0);
    drain(0, 2);
    check("t5_restart_done", done1, 1);
    send_ack();

    // 6: MEM_LAT=3, full 256-byte message, then async reset mid-WAIT
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5a;
    snap = rd_cnt3;
    pulse_fms(1, 8'hff);
    push_msg(255);
    check("t6_mem_rd_e1", rd3, 1);
    tick();
    tick();
    tick();
    check("t6_valid_e3", valid3, 0);
    tick();
    check("t6_valid_e4", valid3, 1);
    drain(1, 256);
    check("t6_done", done3, 1);
    check("t6_addr_no_wrap", addr3, 8'hff);
    check("t6_rd_count", rd_cnt3 - snap, 256);
    check("t6_sb_empty", sb.size(), 0);
    send_ack();

    pulse_fms(1, 8'd5);
    push_msg(5);
    drain(1, 1);
    tick();
    pulse_fms(1, 8'd9);
    check("t6_pre_overrun", ovr3, 1);
    check("t6_pre_data", dout3, 8'h5a);
    check("t6_pre_addr", addr3, 1);
    #3 reset = 1'b1;
    #1;
    check("t6_ar_valid", valid3, 0);
    check("t6_ar_data", dout3, 0);
    check("t6_ar_overrun", ovr3, 0);
    check("t6_ar_done", done3, 0);
    check("t6_ar_last", last3, 0);
    check("t6_ar_mem_rd", rd3, 0);
    check("t6_ar_addr", addr3, 0);
    #2 reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) tick();
    check("t6_post_valid", valid3, 0);
    check("t6_post_mem_rd", rd3, 0);
    check("t6_post_data", dout3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
